axi_lite_slave_regs: RTL and testbench



---
 rtl/axi_lite_pkg.sv | 32 +++
 rtl/axi_lite_regfile.sv | 44 ++++
 rtl/axi_lite_slave_regs.sv | 156 +++++++++++++++
 tb/tb_axi_lite_slave_regs.sv | 501 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: bus widths, response codes, channel state
// encoding and the byte-strobe merge used by register storage.
package axi_lite_pkg;

    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Channel phase encoding, kept identical on the axi_master side.
    typedef enum logic [1:0] {
        CH_IDLE = 2'b00,
        CH_ADDR = 2'b01,
        CH_DATA = 2'b10,
        CH_RESP = 2'b11
    } ch_state_e;

    function automatic logic [DATA_W-1:0] apply_strb(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [STRB_W-1:0] strb
    );
        logic [DATA_W-1:0] merged;
        merged = old_word;
        for (int b = 0; b < STRB_W; b++) begin
            if (strb[b]) merged[8*b +: 8] = new_word[8*b +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/axi_lite_regfile.sv
// Bank of 32-bit software registers: one strobed write port, one
// combinational read port and a flat export of every register.
module axi_lite_regfile
    import axi_lite_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                       ACLK,
    input  logic                       ARESET,
    input  logic                       we_i,
    input  logic [IDX_W-1:0]           wr_idx_i,
    input  logic [DATA_W-1:0]          wr_data_i,
    input  logic [STRB_W-1:0]          wr_strb_i,
    input  logic [IDX_W-1:0]           rd_idx_i,
    output logic [DATA_W-1:0]          rd_data_o,
    output logic [DATA_W*NUM_REGS-1:0] regs_flat_o
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    always_comb begin
        regs_d = regs_q;
        if (we_i) regs_d[wr_idx_i] = apply_strb(regs_q[wr_idx_i], wr_data_i, wr_strb_i);
    end

    // NOTE: this array is flops, not RAM; every entry must clear with reset
    // because software expects all registers to read 0 after reset.
    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rd_data_o = regs_q[rd_idx_i];

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
        assign regs_flat_o[DATA_W*k +: DATA_W] = regs_q[k];
    end

endmodule

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite responder: independent AW/W capture, one outstanding write,
// single-beat reads, all mapped onto axi_lite_regfile.
module axi_lite_slave_regs
    import axi_lite_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 32
) (
    input  logic                       ACLK,
    input  logic                       ARESET,
    input  logic                       AWVALID,
    output logic                       AWREADY,
    input  logic [ADDR_W-1:0]          AWADDR,
    input  logic                       WVALID,
    output logic                       WREADY,
    input  logic [DATA_W-1:0]          WDATA,
    input  logic [STRB_W-1:0]          WSTRB,
    output logic                       BVALID,
    input  logic                       BREADY,
    output logic [1:0]                 BRESP,
    input  logic                       ARVALID,
    output logic                       ARREADY,
    input  logic [ADDR_W-1:0]          ARADDR,
    output logic                       RVALID,
    input  logic                       RREADY,
    output logic [DATA_W-1:0]          RDATA,
    output logic [1:0]                 RRESP,
    output logic [DATA_W*NUM_REGS-1:0] regs_flat
);

    localparam int IDX_W = $clog2(NUM_REGS);

    logic              aw_full_q, aw_full_d;
    logic              w_full_q,  w_full_d;
    logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
    logic [DATA_W-1:0] w_data_q,  w_data_d;
    logic [STRB_W-1:0] w_strb_q,  w_strb_d;
    logic              bvalid_q,  bvalid_d;
    logic [1:0]        bresp_q,   bresp_d;
    logic              rvalid_q,  rvalid_d;
    logic [DATA_W-1:0] rdata_q,   rdata_d;
    logic [1:0]        rresp_q,   rresp_d;

    logic              aw_hs, w_hs, ar_hs, commit;
    logic              aw_in_range, ar_in_range;
    logic [DATA_W-1:0] rd_data;
    logic              unused_addr_bits;

    assign AWREADY = ARESET & ~aw_full_q & ~bvalid_q;
    assign WREADY  = ARESET & ~w_full_q & ~bvalid_q;
    assign ARREADY = ARESET & ~rvalid_q;

    assign aw_hs  = AWVALID & AWREADY;
    assign w_hs   = WVALID & WREADY;
    assign ar_hs  = ARVALID & ARREADY;
    assign commit = aw_full_q & w_full_q & ~bvalid_q;

    assign aw_in_range = (aw_addr_q[ADDR_W-1:IDX_W+2] == '0);
    assign ar_in_range = (ARADDR[ADDR_W-1:IDX_W+2] == '0);

    // Byte offset within a word carries no meaning for word registers.
    assign unused_addr_bits = ^{aw_addr_q[1:0], ARADDR[1:0]};

    axi_lite_regfile #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_regfile (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .we_i        (commit & aw_in_range),
        .wr_idx_i    (aw_addr_q[IDX_W+1:2]),
        .wr_data_i   (w_data_q),
        .wr_strb_i   (w_strb_q),
        .rd_idx_i    (ARADDR[IDX_W+1:2]),
        .rd_data_o   (rd_data),
        .regs_flat_o (regs_flat)
    );

    // NOTE: every next-state value gets a hold default before any branch, so
    // no path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        aw_full_d = aw_full_q;
        w_full_d  = w_full_q;
        aw_addr_d = aw_addr_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;

        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_addr_d = AWADDR;
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            w_data_d = WDATA;
            w_strb_d = WSTRB;
        end

        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = aw_in_range ? RESP_OKAY : RESP_SLVERR;
        end else if (bvalid_q && BREADY) begin
            bvalid_d = 1'b0;
        end

        // The read mux sees pre-commit state, so a same-edge read gets the old value.
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = ar_in_range ? rd_data : '0;
            rresp_d  = ar_in_range ? RESP_OKAY : RESP_SLVERR;
        end else if (rvalid_q && RREADY) begin
            rvalid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments only, so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            aw_full_q <= aw_full_d;
            w_full_q  <= w_full_d;
            aw_addr_q <= aw_addr_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    assign BVALID = bvalid_q;
    assign BRESP  = bresp_q;
    assign RVALID = rvalid_q;
    assign RDATA  = rdata_q;
    assign RRESP  = rresp_q;

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Self-checking bench for axi_lite_slave_regs (NUM_REGS = 8): scenario tasks
// with inline checks plus B/R scoreboards fed from a reference register model.
module tb_axi_lite_slave_regs;

    localparam int NUM_REGS = 8;
    localparam int ADDR_W   = 32;
    localparam int TIMEOUT  = 50;

    logic                  ACLK = 1'b0;
    logic                  ARESET;
    logic                  AWVALID, AWREADY;
    logic [ADDR_W-1:0]     AWADDR;
    logic                  WVALID, WREADY;
    logic [31:0]           WDATA;
    logic [3:0]            WSTRB;
    logic                  BVALID, BREADY;
    logic [1:0]            BRESP;
    logic                  ARVALID, ARREADY;
    logic [ADDR_W-1:0]     ARADDR;
    logic                  RVALID, RREADY;
    logic [31:0]           RDATA;
    logic [1:0]            RRESP;
    logic [32*NUM_REGS-1:0] regs_flat;

    int checks = 0;
    int errors = 0;

    logic [1:0]  exp_b [$];
    logic [33:0] exp_r [$];
    logic [31:0] model [NUM_REGS];
    logic [1:0]  mon_b;
    logic [33:0] mon_r;

    always #5 ACLK = ~ACLK;

    axi_lite_slave_regs #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) dut (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .AWVALID   (AWVALID),
        .AWREADY   (AWREADY),
        .AWADDR    (AWADDR),
        .WVALID    (WVALID),
        .WREADY    (WREADY),
        .WDATA     (WDATA),
        .WSTRB     (WSTRB),
        .BVALID    (BVALID),
        .BREADY    (BREADY),
        .BRESP     (BRESP),
        .ARVALID   (ARVALID),
        .ARREADY   (ARREADY),
        .ARADDR    (ARADDR),
        .RVALID    (RVALID),
        .RREADY    (RREADY),
        .RDATA     (RDATA),
        .RRESP     (RRESP),
        .regs_flat (regs_flat)
    );

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v, input logic [31:0] new_v,
                                                input logic [3:0] strb);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
        return r;
    endfunction

    function automatic bit addr_ok(input logic [31:0] a);
        return a < 32'(NUM_REGS * 4);
    endfunction

    // Scoreboards: compare each response on the negedge before its handshake edge.
    always @(negedge ACLK) begin
        if (ARESET === 1'b1 && BVALID === 1'b1 && BREADY === 1'b1) begin
            checks++;
            if (exp_b.size() == 0) begin
                errors++;
                $display("FAIL b_unexpected: got BRESP=%b with no write outstanding", BRESP);
            end else begin
                mon_b = exp_b.pop_front();
                if (BRESP !== mon_b) begin
                    errors++;
                    $display("FAIL b_resp: got %b expected %b", BRESP, mon_b);
                end
            end
        end
        if (ARESET === 1'b1 && RVALID === 1'b1 && RREADY === 1'b1) begin
            checks++;
            if (exp_r.size() == 0) begin
                errors++;
                $display("FAIL r_unexpected: got RDATA=%h with no read outstanding", RDATA);
            end else begin
                mon_r = exp_r.pop_front();
                if ({RRESP, RDATA} !== mon_r) begin
                    errors++;
                    $display("FAIL r_beat: got resp=%b data=%h expected resp=%b data=%h",
                             RRESP, RDATA, mon_r[33:32], mon_r[31:0]);
                end
            end
        end
    end

    task automatic timeout_fail(input string what);
        checks++;
        errors++;
        $display("FAIL %s_timeout: no handshake within %0d cycles", what, TIMEOUT);
    endtask

    task automatic send_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        bit aw_done = 0, w_done = 0, aw_fire, w_fire;
        int n = 0;
        if (addr_ok(addr)) begin
            exp_b.push_back(2'b00);
            model[addr[4:2]] = merge_bytes(model[addr[4:2]], data, strb);
        end else begin
            exp_b.push_back(2'b10);
        end
        AWVALID = 1; AWADDR = addr; WVALID = 1; WDATA = data; WSTRB = strb;
        while (!(aw_done && w_done) && n < TIMEOUT) begin
            @(negedge ACLK);
            aw_fire = AWVALID && AWREADY;
            w_fire  = WVALID && WREADY;
            @(posedge ACLK); #1;
            if (aw_fire) begin AWVALID = 0; aw_done = 1; end
            if (w_fire)  begin WVALID = 0;  w_done = 1;  end
            n++;
        end
        if (!(aw_done && w_done)) begin
            timeout_fail("write_addr_data");
            AWVALID = 0; WVALID = 0;
        end
    endtask

    task automatic collect_b();
        bit fire = 0;
        int n = 0;
        BREADY = 1;
        while (!fire && n < TIMEOUT) begin
            @(negedge ACLK);
            fire = BVALID;
            @(posedge ACLK); #1;
            n++;
        end
        BREADY = 0;
        if (!fire) timeout_fail("bresp");
    endtask

    task automatic issue_read(input logic [31:0] addr);
        bit fire = 0;
        int n = 0;
        if (addr_ok(addr)) exp_r.push_back({2'b00, model[addr[4:2]]});
        else               exp_r.push_back({2'b10, 32'h0});
        ARVALID = 1; ARADDR = addr;
        while (!fire && n < TIMEOUT) begin
            @(negedge ACLK);
            fire = ARREADY;
            @(posedge ACLK); #1;
            n++;
        end
        ARVALID = 0;
        if (!fire) timeout_fail("araddr");
    endtask

    task automatic collect_r();
        bit fire = 0;
        int n = 0;
        RREADY = 1;
        while (!fire && n < TIMEOUT) begin
            @(negedge ACLK);
            fire = RVALID;
            @(posedge ACLK); #1;
            n++;
        end
        RREADY = 0;
        if (!fire) timeout_fail("rdata");
    endtask

    task automatic test_reset();
        @(negedge ACLK);
        checks++;
        if ({AWREADY, WREADY, ARREADY, BVALID, RVALID} !== 5'b0 || BRESP !== 2'b0 ||
            RRESP !== 2'b0 || RDATA !== 32'h0 || regs_flat !== '0) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b%b%b bv=%b rv=%b bresp=%b rresp=%b rdata=%h regs=%h expected all 0",
                     AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, RDATA, regs_flat);
        end
        @(posedge ACLK); #1;
        ARESET = 1;
        @(negedge ACLK);
        checks++;
        if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
            errors++;
            $display("FAIL reset_release_ready: got %b expected 111", {AWREADY, WREADY, ARREADY});
        end
        @(posedge ACLK); #1;
    endtask

    task automatic test_same_cycle();
        AWVALID = 1; AWADDR = 32'h4; WVALID = 1; WDATA = 32'hDEADBEEF; WSTRB = 4'hF; BREADY = 1;
        exp_b.push_back(2'b00);
        model[1] = 32'hDEADBEEF;
        @(negedge ACLK);
        checks++;
        if ({AWREADY, WREADY} !== 2'b11) begin
            errors++;
            $display("FAIL sc_ready: got %b expected 11", {AWREADY, WREADY});
        end
        @(posedge ACLK); #1;
        AWVALID = 0; WVALID = 0;
        @(negedge ACLK);
        checks++;
        if (BVALID !== 1'b0) begin
            errors++;
            $display("FAIL sc_bvalid_early: got %b expected 0", BVALID);
        end
        @(posedge ACLK); #1;
        @(negedge ACLK);
        checks++;
        if (BVALID !== 1'b1 || regs_flat[63:32] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL sc_commit: bvalid=%b reg1=%h expected 1 deadbeef", BVALID, regs_flat[63:32]);
        end
        @(posedge ACLK); #1;
        BREADY = 0;
        ARVALID = 1; ARADDR = 32'h4; RREADY = 1;
        exp_r.push_back({2'b00, 32'hDEADBEEF});
        @(negedge ACLK);
        checks++;
        if (ARREADY !== 1'b1 || RVALID !== 1'b0) begin
            errors++;
            $display("FAIL sc_ar: arready=%b rvalid=%b expected 1 0", ARREADY, RVALID);
        end
        @(posedge ACLK); #1;
        ARVALID = 0;
        @(negedge ACLK);
        checks++;
        if (RVALID !== 1'b1 || RDATA !== 32'hDEADBEEF || RRESP !== 2'b00) begin
            errors++;
            $display("FAIL sc_read: rvalid=%b rdata=%h rresp=%b expected 1 deadbeef 00", RVALID, RDATA, RRESP);
        end
        @(posedge ACLK); #1;
        RREADY = 0;
        @(negedge ACLK);
        checks++;
        if (RVALID !== 1'b0) begin
            errors++;
            $display("FAIL sc_rvalid_clear: got %b expected 0", RVALID);
        end
        @(posedge ACLK); #1;
    endtask

    // First channel handshakes at edge 0, second at edge 3, commit at edge 4.
    task automatic test_split_order(input bit w_first, input logic [31:0] addr, input logic [31:0] data);
        logic first_rdy;
        exp_b.push_back(2'b00);
        model[addr[4:2]] = data;
        BREADY = 1; AWADDR = addr; WDATA = data; WSTRB = 4'hF;
        if (w_first) WVALID = 1; else AWVALID = 1;
        @(posedge ACLK); #1;
        AWVALID = 0; WVALID = 0;
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) begin
                if (w_first) AWVALID = 1; else WVALID = 1;
            end
            @(negedge ACLK);
            first_rdy = w_first ? WREADY : AWREADY;
            checks++;
            if (first_rdy !== 1'b0 || BVALID !== 1'b0) begin
                errors++;
                $display("FAIL split_hold w_first=%0d cycle %0d: ready=%b bvalid=%b expected 0 0",
                         w_first, c, first_rdy, BVALID);
            end
            @(posedge ACLK); #1;
            AWVALID = 0; WVALID = 0;
        end
        @(negedge ACLK);
        checks++;
        if (BVALID !== 1'b0) begin
            errors++;
            $display("FAIL split_early w_first=%0d: bvalid=%b expected 0", w_first, BVALID);
        end
        @(posedge ACLK); #1;
        @(negedge ACLK);
        checks++;
        if (BVALID !== 1'b1 || regs_flat[32*addr[4:2] +: 32] !== data) begin
            errors++;
            $display("FAIL split_commit w_first=%0d: bvalid=%b reg=%h expected 1 %h",
                     w_first, BVALID, regs_flat[32*addr[4:2] +: 32], data);
        end
        @(posedge ACLK); #1;
        BREADY = 0;
    endtask

    task automatic test_strobe();
        send_write(32'h0, 32'h11223344, 4'hF); collect_b();
        send_write(32'h0, 32'hAABBCCDD, 4'h5); collect_b();
        checks++;
        if (regs_flat[31:0] !== 32'h11BB33DD) begin
            errors++;
            $display("FAIL strobe_merge: got %h expected 11bb33dd", regs_flat[31:0]);
        end
        issue_read(32'h0); collect_r();
        send_write(32'h0, 32'hFFFFFFFF, 4'h0); collect_b();
        checks++;
        if (regs_flat[31:0] !== 32'h11BB33DD) begin
            errors++;
            $display("FAIL strobe_zero: got %h expected 11bb33dd", regs_flat[31:0]);
        end
        send_write(32'h6, 32'h00007700, 4'h2); collect_b();
        issue_read(32'h7); collect_r();
    endtask

    task automatic test_out_of_range();
        logic [32*NUM_REGS-1:0] snap;
        snap = regs_flat;
        send_write(32'h40, 32'hFFFFFFFF, 4'hF); collect_b();
        send_write(32'h80000004, 32'h12345678, 4'hF); collect_b();
        checks++;
        if (regs_flat !== snap) begin
            errors++;
            $display("FAIL oor_no_change: regs=%h expected %h", regs_flat, snap);
        end
        issue_read(32'h40); collect_r();
        issue_read(32'h20); collect_r();
        issue_read(32'h1F); collect_r();
    endtask

    task automatic test_backpressure();
        logic [31:0] hold_data;
        int n = 0;
        send_write(32'h44, 32'h1, 4'hF);
        while (BVALID !== 1'b1 && n < TIMEOUT) begin
            @(negedge ACLK); @(posedge ACLK); #1;
            n++;
        end
        if (n == TIMEOUT) timeout_fail("bp_bvalid");
        for (int c = 0; c < 5; c++) begin
            @(negedge ACLK);
            checks++;
            if (BVALID !== 1'b1 || BRESP !== 2'b10 || AWREADY !== 1'b0 || WREADY !== 1'b0) begin
                errors++;
                $display("FAIL bp_b_hold cycle %0d: bvalid=%b bresp=%b awready=%b wready=%b expected 1 10 0 0",
                         c, BVALID, BRESP, AWREADY, WREADY);
            end
            @(posedge ACLK); #1;
        end
        collect_b();
        hold_data = model[7];
        issue_read(32'h1C);
        for (int c = 0; c < 5; c++) begin
            @(negedge ACLK);
            checks++;
            if (RVALID !== 1'b1 || RDATA !== hold_data || RRESP !== 2'b00 || ARREADY !== 1'b0) begin
                errors++;
                $display("FAIL bp_r_hold cycle %0d: rvalid=%b rdata=%h rresp=%b arready=%b expected 1 %h 00 0",
                         c, RVALID, RDATA, RRESP, ARREADY, hold_data);
            end
            @(posedge ACLK); #1;
        end
        collect_r();
    endtask

    task automatic test_same_edge_rw();
        send_write(32'hC, 32'h33333333, 4'hF); collect_b();
        AWVALID = 1; AWADDR = 32'hC; WVALID = 1; WDATA = 32'h44444444; WSTRB = 4'hF;
        BREADY = 1; RREADY = 1;
        @(posedge ACLK); #1;
        AWVALID = 0; WVALID = 0;
        ARVALID = 1; ARADDR = 32'hC;
        exp_r.push_back({2'b00, 32'h33333333});
        exp_b.push_back(2'b00);
        model[3] = 32'h44444444;
        @(posedge ACLK); #1;
        ARVALID = 0;
        @(negedge ACLK);
        checks++;
        if (RDATA !== 32'h33333333 || regs_flat[127:96] !== 32'h44444444) begin
            errors++;
            $display("FAIL same_edge: rdata=%h reg3=%h expected 33333333 44444444", RDATA, regs_flat[127:96]);
        end
        @(posedge ACLK); #1;
        BREADY = 0; RREADY = 0;
        issue_read(32'hC); collect_r();
    endtask

    task automatic test_back_to_back();
        int stalls = 0;
        for (int k = 4; k < 8; k++) begin
            send_write(32'(4 * k), $urandom, 4'($urandom_range(0, 15)));
            collect_b();
        end
        RREADY = 1;
        for (int k = 4; k < 8; k++) begin
            bit fire = 0;
            int n = 0;
            ARVALID = 1; ARADDR = 32'(4 * k);
            exp_r.push_back({2'b00, model[k]});
            while (!fire && n < TIMEOUT) begin
                @(negedge ACLK);
                fire = ARREADY;
                if (!fire) stalls++;
                @(posedge ACLK); #1;
                n++;
            end
            if (!fire) timeout_fail("b2b_ar");
        end
        ARVALID = 0;
        @(negedge ACLK);
        @(posedge ACLK); #1;
        RREADY = 0;
        checks++;
        if (stalls !== 3) begin
            errors++;
            $display("FAIL b2b_rate: got %0d stall cycles expected 3", stalls);
        end
    endtask

    task automatic test_reset_mid();
        AWVALID = 1; AWADDR = 32'h8;
        @(negedge ACLK);
        @(posedge ACLK); #1;
        AWVALID = 0;
        issue_read(32'h4);
        @(negedge ACLK);
        checks++;
        if (RVALID !== 1'b1 || AWREADY !== 1'b0) begin
            errors++;
            $display("FAIL rm_pre: rvalid=%b awready=%b expected 1 0", RVALID, AWREADY);
        end
        #2 ARESET = 0;
        #1;
        checks++;
        if ({AWREADY, WREADY, ARREADY, BVALID, RVALID} !== 5'b0 || RDATA !== 32'h0 ||
            RRESP !== 2'b0 || BRESP !== 2'b0 || regs_flat !== '0) begin
            errors++;
            $display("FAIL rm_async: rdy=%b%b%b bv=%b rv=%b rdata=%h regs=%h expected all 0",
                     AWREADY, WREADY, ARREADY, BVALID, RVALID, RDATA, regs_flat);
        end
        exp_b.delete();
        exp_r.delete();
        for (int k = 0; k < NUM_REGS; k++) model[k] = '0;
        @(posedge ACLK); #1;
        ARESET = 1;
        WVALID = 1; WDATA = 32'hCAFEF00D; WSTRB = 4'hF;
        @(negedge ACLK);
        @(posedge ACLK); #1;
        WVALID = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge ACLK);
            checks++;
            if (BVALID !== 1'b0 || WREADY !== 1'b0) begin
                errors++;
                $display("FAIL rm_stale cycle %0d: bvalid=%b wready=%b expected 0 0", c, BVALID, WREADY);
            end
            @(posedge ACLK); #1;
        end
        exp_b.push_back(2'b00);
        model[3] = 32'hCAFEF00D;
        AWVALID = 1; AWADDR = 32'hC;
        @(negedge ACLK);
        @(posedge ACLK); #1;
        AWVALID = 0;
        collect_b();
        checks++;
        if (regs_flat[95:64] !== 32'h0 || regs_flat[127:96] !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL rm_after: reg2=%h reg3=%h expected 00000000 cafef00d",
                     regs_flat[95:64], regs_flat[127:96]);
        end
    endtask

    initial begin
        ARESET = 0;
        AWVALID = 0; AWADDR = '0; WVALID = 0; WDATA = '0; WSTRB = '0; BREADY = 0;
        ARVALID = 0; ARADDR = '0; RREADY = 0;
        for (int k = 0; k < NUM_REGS; k++) model[k] = '0;

        test_reset();
        test_same_cycle();
        test_split_order(1'b1, 32'h8,  32'hA5A50F0F);
        test_split_order(1'b0, 32'h1C, 32'h0BADF00D);
        test_strobe();
        test_out_of_range();
        test_backpressure();
        test_same_edge_rw();
        test_back_to_back();
        test_reset_mid();

        checks++;
        if (exp_b.size() != 0 || exp_r.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d B and %0d R responses still expected, expected 0 and 0",
                     exp_b.size(), exp_r.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
